// File: rtl/servo_pkg.sv
// servo_pkg: position width, centre value and ramp FSM encoding.
// Shared between servo_ramp and the servo PWM driver.
package servo_pkg;

  localparam int POS_W = 8;

  localparam logic [POS_W-1:0] POS_CENTER = 8'd128;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_e;

  function automatic logic [POS_W:0] sat_min(
    input logic [POS_W:0] a,
    input logic [POS_W:0] b
  );
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// servo_tick_gen: free-running CLK_DIV divider, held at 0 by clr.
// tick is high in the last count of each period.
module servo_tick_gen #(
  parameter int CLK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CTR_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CTR_W-1:0] LAST = CTR_W'(CLK_DIV - 1);

  logic [CTR_W-1:0] ctr_q;
  logic [CTR_W-1:0] ctr_d;

  assign tick = (ctr_q == LAST);

  always_comb begin
    ctr_d = ctr_q + 1'b1;
    if (clr || tick) begin
      ctr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_q <= '0;
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/servo_ramp.sv
// servo_ramp: slew-rate limited servo position with valid/ready target.
// Define SERVO_RAMP_CLAMP_EN to clamp targets into [POS_MIN, POS_MAX].
module servo_ramp
  import servo_pkg::*;
#(
  parameter int               CLK_DIV   = 50000,
  parameter int               STEP      = 1,
  parameter logic [POS_W-1:0] POS_RESET = POS_CENTER,
  parameter logic [POS_W-1:0] POS_MIN   = 8'd0,
  parameter logic [POS_W-1:0] POS_MAX   = 8'd255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [POS_W-1:0] tgt_pos,
  output logic [POS_W-1:0] pos,
  output logic             busy,
  output logic             done
);

  localparam logic [POS_W:0] STEP9 = (POS_W+1)'(STEP);

  state_e           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] tgt_q, tgt_d;
  logic             done_q, done_d;
  logic [POS_W-1:0] tgt_eff;
  logic             tick;
  logic             up;
  logic [POS_W:0]   mag;
  logic [POS_W:0]   stp;
  logic [POS_W-1:0] pos_nx;
  logic             arrive;

  generate
    if (POS_MIN > POS_MAX || STEP < 1 || STEP > 255 || CLK_DIV < 2)
    begin : g_bad_cfg
      localparam int BadCfg = 1;
    end
  endgenerate

`ifdef SERVO_RAMP_CLAMP_EN
  always_comb begin
    tgt_eff = tgt_pos;
    if (tgt_pos < POS_MIN) tgt_eff = POS_MIN;
    if (tgt_pos > POS_MAX) tgt_eff = POS_MAX;
  end
`else
  assign tgt_eff = tgt_pos;
`endif

  servo_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (state_q == ST_IDLE),
    .tick(tick)
  );

  // Magnitude plus direction; the step saturates so pos never overshoots.
  always_comb begin
    up     = (tgt_q > pos_q);
    mag    = up ? ({1'b0, tgt_q} - {1'b0, pos_q})
                : ({1'b0, pos_q} - {1'b0, tgt_q});
    stp    = sat_min(mag, STEP9);
    pos_nx = up ? (pos_q + stp[POS_W-1:0])
                : (pos_q - stp[POS_W-1:0]);
    arrive = (mag <= STEP9);
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    tgt_d   = tgt_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (tgt_valid) begin
          tgt_d = tgt_eff;
          if (tgt_eff == pos_q) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RAMP;
          end
        end
      end
      ST_RAMP: begin
        if (tick) begin
          pos_d = pos_nx;
          if (arrive) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pos_q   <= POS_RESET;
      tgt_q   <= POS_RESET;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      tgt_q   <= tgt_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q == ST_RAMP);
  assign tgt_ready = (state_q == ST_IDLE);
  assign pos       = pos_q;
  assign done      = done_q;

endmodule
